// File: rtl/xif_result_queue_if.sv
// Result-path bundle between FPU producer channels, the XIF commit channel and the
// CPU result port. The queue itself uses the slave modport.
interface xif_result_queue_if #(
    parameter int NUM_CH      = 4,
    parameter int DEPTH       = 8,
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFW_WIDTH = 32,
    parameter int XLEN        = 32
);
    localparam int WEW  = X_RFW_WIDTH / XLEN;
    localparam int CNTW = $clog2(DEPTH) + 1;

    logic [NUM_CH-1:0]             in_valid;
    logic [NUM_CH-1:0]             in_ready;
    logic [NUM_CH*X_ID_WIDTH-1:0]  in_id;
    logic [NUM_CH*X_RFW_WIDTH-1:0] in_data;
    logic [NUM_CH*5-1:0]           in_rd;
    logic [NUM_CH*WEW-1:0]         in_we;
    logic [NUM_CH-1:0]             in_exc;
    logic [NUM_CH*6-1:0]           in_exccode;

    logic                          commit_valid;
    logic [X_ID_WIDTH-1:0]         commit_id;
    logic                          commit_kill;

    logic                          result_valid;
    logic                          result_ready;
    logic [X_ID_WIDTH-1:0]         result_id;
    logic [X_RFW_WIDTH-1:0]        result_data;
    logic [4:0]                    result_rd;
    logic [WEW-1:0]                result_we;
    logic                          result_exc;
    logic [5:0]                    result_exccode;
    logic [CNTW-1:0]               count;

    modport master (
        output in_valid, in_id, in_data, in_rd, in_we, in_exc, in_exccode,
        output commit_valid, commit_id, commit_kill, result_ready,
        input  in_ready, result_valid, result_id, result_data, result_rd,
        input  result_we, result_exc, result_exccode, count
    );

    modport slave (
        input  in_valid, in_id, in_data, in_rd, in_we, in_exc, in_exccode,
        input  commit_valid, commit_id, commit_kill, result_ready,
        output in_ready, result_valid, result_id, result_data, result_rd,
        output result_we, result_exc, result_exccode, count
    );
endinterface

// File: rtl/xif_result_queue.sv
// Round-robin collector of FPU channel results into a FIFO feeding the XIF result port;
// entries killed through the commit channel are dropped silently at the head.
module xif_result_queue #(
    parameter int NUM_CH      = 4,
    parameter int DEPTH       = 8,
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFW_WIDTH = 32,
    parameter int XLEN        = 32
) (
    input logic             clk,
    input logic             reset,
    xif_result_queue_if.slave xif
);
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int WEW = X_RFW_WIDTH / XLEN;
    localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef struct packed {
        logic                   live;
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_RFW_WIDTH-1:0] data;
        logic [4:0]             rd;
        logic [WEW-1:0]         we;
        logic                   exc;
        logic [5:0]             exccode;
    } entry_t;

    entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]      rr_q, rr_d;

    logic               empty, full, kill, pop, grant_vld;
    logic [CW-1:0]      gsel;
    logic [NUM_CH-1:0]  grant;
    entry_t             head, wr_ent;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign kill  = xif.commit_valid && xif.commit_kill;
    assign head  = mem_q[rptr_q[AW-1:0]];
    assign pop   = !empty && (!head.live || xif.result_ready);

    // Search starts one past the last winner; grants are also held off during reset.
    always_comb begin
        grant_vld = 1'b0;
        gsel      = '0;
        grant     = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!grant_vld && !full && !reset && xif.in_valid[i] &&
                    (i == (int'(rr_q) + k) % NUM_CH)) begin
                    grant_vld = 1'b1;
                    grant[i]  = 1'b1;
                    gsel      = CW'(i);
                end
            end
        end
    end

    always_comb begin
        wr_ent = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                wr_ent.id      = xif.in_id[i*X_ID_WIDTH +: X_ID_WIDTH];
                wr_ent.data    = xif.in_data[i*X_RFW_WIDTH +: X_RFW_WIDTH];
                wr_ent.rd      = xif.in_rd[i*5 +: 5];
                wr_ent.we      = xif.in_we[i*WEW +: WEW];
                wr_ent.exc     = xif.in_exc[i];
                wr_ent.exccode = xif.in_exccode[i*6 +: 6];
            end
        end
        wr_ent.live = !(kill && (wr_ent.id == xif.commit_id));
    end

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        rr_d   = rr_q;
        // Kill sweeps every slot; stale free slots are harmless and get overwritten on write.
        if (kill) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (mem_q[j].id == xif.commit_id) mem_d[j].live = 1'b0;
            end
        end
        if (grant_vld) begin
            mem_d[wptr_q[AW-1:0]] = wr_ent;
            wptr_d                = wptr_q + PW'(1);
            rr_d                  = gsel;
        end
        if (pop) rptr_d = rptr_q + PW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            rr_q   <= CW'(NUM_CH - 1);
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            rr_q   <= rr_d;
        end
    end

    assign xif.in_ready       = grant;
    assign xif.result_valid   = !empty && head.live;
    assign xif.result_id      = head.id;
    assign xif.result_data    = head.data;
    assign xif.result_rd      = head.rd;
    assign xif.result_we      = head.we;
    assign xif.result_exc     = head.exc;
    assign xif.result_exccode = head.exccode;
    assign xif.count          = wptr_q - rptr_q;
endmodule

// File: tb/tb_xif_result_queue.sv
// Bench for xif_result_queue: directed scenarios followed by random traffic, all checked
// against a queue-based reference model updated on each clock edge.
module tb_xif_result_queue;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 8;
    localparam int IDW    = 4;
    localparam int RFW    = 32;
    localparam int XL     = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    xif_result_queue_if #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .X_ID_WIDTH(IDW),
                          .X_RFW_WIDTH(RFW), .XLEN(XL)) xif ();

    xif_result_queue #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .X_ID_WIDTH(IDW),
                       .X_RFW_WIDTH(RFW), .XLEN(XL)) dut (
        .clk   (clk),
        .reset (reset),
        .xif   (xif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           live;
        logic [IDW-1:0] id;
        logic [RFW-1:0] data;
        logic [4:0]     rd;
        logic [0:0]     we;
        logic           exc;
        logic [5:0]     exccode;
    } ent_t;

    ent_t mq[$];
    int   rr = NUM_CH - 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_grant();
        if (reset || mq.size() >= DEPTH) return -1;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (xif.in_valid[(rr + k) % NUM_CH]) return (rr + k) % NUM_CH;
        end
        return -1;
    endfunction

    // Reference model: head drops (delivered or silent), kill sweep, then new entry.
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            mq.delete();
            rr = NUM_CH - 1;
        end else begin
            int   g;
            logic kl;
            ent_t e;
            g  = exp_grant();
            kl = xif.commit_valid && xif.commit_kill;
            if (mq.size() > 0 && (!mq[0].live || xif.result_ready)) void'(mq.pop_front());
            if (kl) begin
                foreach (mq[j]) if (mq[j].id == xif.commit_id) mq[j].live = 1'b0;
            end
            if (g >= 0) begin
                e.id      = xif.in_id[g*IDW +: IDW];
                e.data    = xif.in_data[g*RFW +: RFW];
                e.rd      = xif.in_rd[g*5 +: 5];
                e.we      = xif.in_we[g +: 1];
                e.exc     = xif.in_exc[g];
                e.exccode = xif.in_exccode[g*6 +: 6];
                e.live    = !(kl && e.id == xif.commit_id);
                mq.push_back(e);
                rr = g;
            end
        end
    end

    // Monitor: compares DUT outputs against the model between clock edges.
    initial forever begin
        int               g;
        logic [NUM_CH-1:0] er;
        logic             ev;
        @(negedge clk);
        #1;
        g  = exp_grant();
        er = (g >= 0) ? NUM_CH'(1 << g) : '0;
        ev = (mq.size() > 0) && mq[0].live;
        chk("in_ready", xif.in_ready, er);
        chk("count", xif.count, mq.size());
        chk("result_valid", xif.result_valid, ev);
        if (ev) begin
            chk("result_id", xif.result_id, mq[0].id);
            chk("result_data", xif.result_data, mq[0].data);
            chk("result_rd", xif.result_rd, mq[0].rd);
            chk("result_we", xif.result_we, mq[0].we);
            chk("result_exc", xif.result_exc, mq[0].exc);
            chk("result_exccode", xif.result_exccode, mq[0].exccode);
        end
    end

    task automatic rand_fields();
        for (int i = 0; i < NUM_CH; i++) begin
            xif.in_id[i*IDW +: IDW]     = IDW'($urandom_range(0, 7));
            xif.in_data[i*RFW +: RFW]   = $urandom;
            xif.in_rd[i*5 +: 5]         = 5'($urandom);
            xif.in_we[i]                = 1'($urandom);
            xif.in_exc[i]               = 1'($urandom);
            xif.in_exccode[i*6 +: 6]    = 6'($urandom);
        end
    endtask

    task automatic set_id(input int ch, input int id);
        xif.in_id[ch*IDW +: IDW] = IDW'(id);
    endtask

    task automatic cyc(input logic [NUM_CH-1:0] v, input logic rdy, input logic cv,
                       input logic ck, input int cid);
        @(negedge clk);
        xif.in_valid     = v;
        xif.result_ready = rdy;
        xif.commit_valid = cv;
        xif.commit_kill  = ck;
        xif.commit_id    = IDW'(cid);
        rand_fields();
    endtask

    initial begin
        xif.in_valid     = '0;
        xif.result_ready = 1'b0;
        xif.commit_valid = 1'b0;
        xif.commit_kill  = 1'b0;
        xif.commit_id    = '0;
        rand_fields();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Round-robin order from reset, then drain in grant order
        for (int c = 0; c < 4; c++) begin
            cyc(4'hf, 0, 0, 0, 0);
            for (int i = 0; i < NUM_CH; i++) set_id(i, i);
        end
        repeat (6) cyc(4'h0, 1, 0, 0, 0);

        // Fill to full, one pop, refill, drain
        repeat (10) cyc(4'hf, 0, 0, 0, 0);
        cyc(4'hf, 1, 0, 0, 0);
        repeat (2) cyc(4'hf, 0, 0, 0, 0);
        repeat (12) cyc(4'h0, 1, 0, 0, 0);

        // Kill of a repeated id
        cyc(4'h1, 0, 0, 0, 0); set_id(0, 3);
        cyc(4'h1, 0, 0, 0, 0); set_id(0, 5);
        cyc(4'h1, 0, 0, 0, 0); set_id(0, 3);
        cyc(4'h0, 0, 1, 1, 3);
        repeat (5) cyc(4'h0, 1, 0, 0, 0);

        // Kill colliding with an incoming grant, then with a transferring head
        cyc(4'h2, 0, 1, 1, 7); set_id(1, 7);
        repeat (2) cyc(4'h0, 1, 0, 0, 0);
        cyc(4'h4, 0, 0, 0, 0); set_id(2, 9);
        cyc(4'h0, 1, 1, 1, 9);
        repeat (2) cyc(4'h0, 1, 0, 0, 0);

        // Head held under backpressure
        cyc(4'h8, 0, 0, 0, 0); set_id(3, 2);
        repeat (5) cyc(4'h0, 0, 0, 0, 0);
        repeat (2) cyc(4'h0, 1, 0, 0, 0);

        // Asynchronous reset with entries queued
        repeat (3) cyc(4'hf, 0, 0, 0, 0);
        @(negedge clk);
        #3 reset = 1'b1;
        #1;
        chk("reset_count", xif.count, 0);
        chk("reset_valid", xif.result_valid, 0);
        chk("reset_in_ready", xif.in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        xif.in_valid = '0;

        // Random traffic
        repeat (1500) begin
            cyc(NUM_CH'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                1'($urandom), $urandom_range(0, 7));
        end
        repeat (12) cyc(4'h0, 1, 0, 0, 0);
        @(negedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
